alu_issue_queue: RTL

Buffered front-end for the ALU. It accepts operation requests (opcode, two 8-bit operands) over a valid/ready handshake and queues them in a small FIFO. It issues the head entry to an instantiated ALU and returns registered results, with Zero and illegal-opcode flags, over a second valid/ready handshake. It sits between instruction decode/microcode and the writeback path, decoupling ALU consumers that may stall.

---
 rtl/alu_issue_queue_pkg.sv | 34 +++
 rtl/alu_issue_queue_if.sv | 25 ++
 rtl/alu_issue_queue_alu.sv | 32 +++
 rtl/alu_issue_queue.sv | 125 ++++++++++++
 4 files changed

// File: rtl/alu_issue_queue_pkg.sv
// Shared definitions for the ALU issue queue: opcodes, the FIFO entry type and
// opcode legality decode.
package alu_issue_queue_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [3:0] {
        OP_LSH = 4'b0000,
        OP_RSH = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_GEQ = 4'b1000,
        OP_EQ  = 4'b1001,
        OP_NEG = 4'b1010,
        OP_ADD = 4'b1011,
        OP_NEQ = 4'b1101
    } alu_op_e;

    // Opcode is carried raw so undefined codes survive the queue and can be flagged.
    typedef struct packed {
        logic [3:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_LSH, OP_RSH, OP_AND, OP_OR,
            OP_GEQ, OP_EQ, OP_NEG, OP_ADD, OP_NEQ: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Request and response handshakes of the ALU issue queue.
interface alu_issue_queue_if #(
    parameter int W = 8
);
    logic         ReqValid;
    logic         ReqReady;
    logic [3:0]   ReqOp;
    logic [W-1:0] ReqA;
    logic [W-1:0] ReqB;
    logic         RspValid;
    logic         RspReady;
    logic [W-1:0] RspOut;
    logic         RspZero;
    logic         RspIllegal;

    modport master (
        output ReqValid, ReqOp, ReqA, ReqB, RspReady,
        input  ReqReady, RspValid, RspOut, RspZero, RspIllegal
    );

    modport slave (
        input  ReqValid, ReqOp, ReqA, ReqB, RspReady,
        output ReqReady, RspValid, RspOut, RspZero, RspIllegal
    );
endinterface

// File: rtl/alu_issue_queue_alu.sv
// Combinational ALU; undefined opcodes produce zero and are flagged by the caller.
module alu_issue_queue_alu
    import alu_issue_queue_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] InputA,
    input  logic [W-1:0] InputB,
    input  logic [3:0]   OP,
    output logic [W-1:0] Out,
    output logic         Zero
);

    always_comb begin
        Out = '0;
        case (OP)
            OP_LSH:  Out = {InputA[W-2:0], 1'b0};
            OP_RSH:  Out = {1'b0, InputA[W-1:1]};
            OP_AND:  Out = InputA & InputB;
            OP_OR:   Out = InputA | InputB;
            OP_GEQ:  Out = {{(W-1){1'b0}}, (InputA >= InputB)};
            OP_EQ:   Out = {{(W-1){1'b0}}, (InputA == InputB)};
            OP_NEG:  Out = (~InputA) + W'(1);
            OP_ADD:  Out = InputA + InputB;
            OP_NEQ:  Out = {{(W-1){1'b0}}, (InputA != InputB)};
            default: Out = '0;
        endcase
    end

    assign Zero = (Out == '0);

endmodule

// File: rtl/alu_issue_queue.sv
// Request FIFO in front of the ALU with a registered, back-pressurable result stage.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    alu_issue_queue_if.slave   bus,
    output logic [7:0]         DoneCount,
    output logic               Busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    req_t             mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [W-1:0]     rsp_out_q, rsp_out_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_illegal_q, rsp_illegal_d;
    logic [7:0]       done_count_q, done_count_d;

    logic             empty;
    logic             push;
    logic             issue;
    logic             rsp_fire;
    logic             head_legal;
    logic [W-1:0]     alu_out;
    logic             alu_zero;
    req_t             head;

    assign empty    = (count_q == '0);
    assign head     = mem_q[rd_ptr_q];
    // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign bus.ReqReady = !Reset && (count_q != CNT_W'(DEPTH));
    assign push     = bus.ReqValid && bus.ReqReady;
    assign issue    = !empty && (!rsp_valid_q || bus.RspReady);
    assign rsp_fire = rsp_valid_q && bus.RspReady;

    alu_issue_queue_alu #(.W(W)) u_alu (
        .InputA (head.a),
        .InputB (head.b),
        .OP     (head.op),
        .Out    (alu_out),
        .Zero   (alu_zero)
    );

    assign head_legal = op_is_legal(head.op);

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_out_d     = rsp_out_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_illegal_d = rsp_illegal_q;
        done_count_d  = done_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, issue})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (rsp_fire) begin
            done_count_d = done_count_q + 8'd1;
            rsp_valid_d  = 1'b0;
        end
        if (issue) begin
            rsp_valid_d   = 1'b1;
            rsp_out_d     = head_legal ? alu_out : '0;
            rsp_zero_d    = head_legal ? alu_zero : 1'b1;
            rsp_illegal_d = !head_legal;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_out_q     <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
            done_count_q  <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_out_q     <= rsp_out_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_illegal_q <= rsp_illegal_d;
            done_count_q  <= done_count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op: bus.ReqOp, a: bus.ReqA, b: bus.ReqB};
        end
    end

    assign bus.RspValid   = rsp_valid_q;
    assign bus.RspOut     = rsp_out_q;
    assign bus.RspZero    = rsp_zero_q;
    assign bus.RspIllegal = rsp_illegal_q;
    assign DoneCount      = done_count_q;
    assign Busy           = !empty || rsp_valid_q;

endmodule
